// File: rtl/dl_sync_fifo_if.sv
// Handshake bundle for dl_sync_fifo: write/read requests, control strobes and status flags.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface dl_sync_fifo_if #(
    parameter int DW = 10,
    parameter int AW = 7
);
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          flush;
    logic          clr_err;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          underflow;

    modport master (
        output wr_en, wr_data, rd_en, flush, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, flush, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/dl_sync_fifo.sv
// Single-clock FIFO with registered level/flags, sticky overflow/underflow and synchronous flush.
// Optional macro DL_FIFO_ZERO_RDATA_EN forces rd_data to zero on every edge without an accepted read.
module dl_sync_fifo #(
    parameter int DW         = 10,
    parameter int AW         = 7,
    parameter int AFULL_THR  = 120,
    parameter int AEMPTY_THR = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    dl_sync_fifo_if.slave    bus
);

    localparam logic [AW:0] DEPTH_L    = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE_L      = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] AFULL_L    = (AW+1)'(AFULL_THR);
    localparam logic [AW:0] AEMPTY_L   = (AW+1)'(AEMPTY_THR);

    logic [DW-1:0] mem_r [2**AW];

    logic [AW:0]   wptr_r;
    logic [AW:0]   rptr_r;
    logic [AW:0]   level_r;
    logic          full_r;
    logic          empty_r;
    logic          afull_r;
    logic          aempty_r;
    logic [DW-1:0] rd_data_r;
    logic          rd_valid_r;
    logic          ovf_r;
    logic          unf_r;

    logic          wr_acc_s;
    logic          rd_acc_s;
    logic [AW:0]   wptr_nxt_s;
    logic [AW:0]   rptr_nxt_s;
    logic [AW:0]   level_nxt_s;
    logic          full_nxt_s;
    logic          empty_nxt_s;
    logic          afull_nxt_s;
    logic          aempty_nxt_s;
    logic [DW-1:0] rd_data_nxt_s;
    logic          ovf_nxt_s;
    logic          unf_nxt_s;

    // Acceptance, pointer/level next-state and post-edge flag computation
    always_comb begin
        wr_acc_s      = bus.wr_en && !full_r  && !bus.flush;
        rd_acc_s      = bus.rd_en && !empty_r && !bus.flush;
        wptr_nxt_s    = wptr_r;
        rptr_nxt_s    = rptr_r;
        level_nxt_s   = level_r;
        rd_data_nxt_s = rd_data_r;
        ovf_nxt_s     = ovf_r;
        unf_nxt_s     = unf_r;

        if (bus.flush) begin
            wptr_nxt_s  = {(AW+1){1'b0}};
            rptr_nxt_s  = {(AW+1){1'b0}};
            level_nxt_s = {(AW+1){1'b0}};
        end else begin
            if (wr_acc_s) begin
                wptr_nxt_s = wptr_r + ONE_L;
            end else begin
                wptr_nxt_s = wptr_r;
            end
            if (rd_acc_s) begin
                rptr_nxt_s = rptr_r + ONE_L;
            end else begin
                rptr_nxt_s = rptr_r;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   level_nxt_s = level_r + ONE_L;
                2'b01:   level_nxt_s = level_r - ONE_L;
                default: level_nxt_s = level_r;
            endcase
        end

        full_nxt_s   = (level_nxt_s == DEPTH_L);
        empty_nxt_s  = (level_nxt_s == {(AW+1){1'b0}});
        afull_nxt_s  = (level_nxt_s >= AFULL_L);
        aempty_nxt_s = (level_nxt_s <= AEMPTY_L);

        // Read data comes straight from the array; a same-edge write is never visible
        if (rd_acc_s) begin
            rd_data_nxt_s = mem_r[rptr_r[AW-1:0]];
        end else begin
`ifdef DL_FIFO_ZERO_RDATA_EN
            rd_data_nxt_s = {DW{1'b0}};
`else
            rd_data_nxt_s = rd_data_r;
`endif
        end

        // Set beats clear on a coincident edge; flush suppresses error detection
        if (bus.wr_en && full_r && !bus.flush) begin
            ovf_nxt_s = 1'b1;
        end else if (bus.clr_err) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
        if (bus.rd_en && empty_r && !bus.flush) begin
            unf_nxt_s = 1'b1;
        end else if (bus.clr_err) begin
            unf_nxt_s = 1'b0;
        end else begin
            unf_nxt_s = unf_r;
        end
    end

    // Storage array; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wptr_r[AW-1:0]] <= bus.wr_data;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r     <= {(AW+1){1'b0}};
            rptr_r     <= {(AW+1){1'b0}};
            level_r    <= {(AW+1){1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            afull_r    <= 1'b0;
            aempty_r   <= 1'b1;
            rd_data_r  <= {DW{1'b0}};
            rd_valid_r <= 1'b0;
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
        end else begin
            wptr_r     <= wptr_nxt_s;
            rptr_r     <= rptr_nxt_s;
            level_r    <= level_nxt_s;
            full_r     <= full_nxt_s;
            empty_r    <= empty_nxt_s;
            afull_r    <= afull_nxt_s;
            aempty_r   <= aempty_nxt_s;
            rd_data_r  <= rd_data_nxt_s;
            rd_valid_r <= rd_acc_s;
            ovf_r      <= ovf_nxt_s;
            unf_r      <= unf_nxt_s;
        end
    end

    assign bus.rd_data      = rd_data_r;
    assign bus.rd_valid     = rd_valid_r;
    assign bus.full         = full_r;
    assign bus.empty        = empty_r;
    assign bus.almost_full  = afull_r;
    assign bus.almost_empty = aempty_r;
    assign bus.level        = level_r;
    assign bus.overflow     = ovf_r;
    assign bus.underflow    = unf_r;

endmodule

// File: tb/tb_dl_sync_fifo.sv
// Directed plus randomized bench for dl_sync_fifo against a queue-based reference model.
module tb_dl_sync_fifo;
    localparam int DW    = 10;
    localparam int AW    = 7;
    localparam int DEPTH = 2**AW;
    localparam int AFT   = 120;
    localparam int AET   = 8;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    logic [DW-1:0] q[$];
    logic [DW-1:0] e_rd;
    logic          e_rv;
    logic          e_ovf;
    logic          e_unf;

    dl_sync_fifo_if #(.DW(DW), .AW(AW)) bus ();

    dl_sync_fifo #(.DW(DW), .AW(AW), .AFULL_THR(AFT), .AEMPTY_THR(AET)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".level"},        32'(bus.level),        32'(n));
        chk({tag, ".full"},         32'(bus.full),         32'(n == DEPTH));
        chk({tag, ".empty"},        32'(bus.empty),        32'(n == 0));
        chk({tag, ".almost_full"},  32'(bus.almost_full),  32'(n >= AFT));
        chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(n <= AET));
        chk({tag, ".rd_valid"},     32'(bus.rd_valid),     32'(e_rv));
        chk({tag, ".rd_data"},      32'(bus.rd_data),      32'(e_rd));
        chk({tag, ".overflow"},     32'(bus.overflow),     32'(e_ovf));
        chk({tag, ".underflow"},    32'(bus.underflow),    32'(e_unf));
    endtask

    // One clock: apply inputs, advance the model by the FIFO rules, compare everything
    task automatic step(input string tag, input logic w, input logic [DW-1:0] d,
                        input logic r, input logic f, input logic c);
        logic wa;
        logic ra;
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = r;
        bus.flush   = f;
        bus.clr_err = c;
        wa = w && (q.size() < DEPTH) && !f;
        ra = r && (q.size() > 0) && !f;
        if (w && (q.size() == DEPTH) && !f) e_ovf = 1'b1;
        else if (c)                         e_ovf = 1'b0;
        if (r && (q.size() == 0) && !f)     e_unf = 1'b1;
        else if (c)                         e_unf = 1'b0;
        @(posedge clk);
        #1;
        if (ra) begin
            e_rd = q.pop_front();
        end else begin
`ifdef DL_FIFO_ZERO_RDATA_EN
            e_rd = '0;
`endif
        end
        if (f) q.delete();
        else if (wa) q.push_back(d);
        e_rv = ra;
        check_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        e_rd  = '0;
        e_rv  = 1'b0;
        e_ovf = 1'b0;
        e_unf = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] pat;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.flush   = 1'b0;
        bus.clr_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("reset");
        step("idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Fill to full with 0x001..0x080, then drain in order
        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        step("ovf_wr", 1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0);
        step("ovf_wr_rd", 1'b1, 10'h3FF, 1'b1, 1'b0, 1'b0);
        step("refill", 1'b1, 10'h080, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("clr_ovf", 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Level 5, then concurrent read/write stream across several pointer wraps
        pat = 10'h100;
        for (int i = 0; i < 5; i++) begin
            step("pre5", 1'b1, pat, 1'b0, 1'b0, 1'b0);
            pat = pat + 10'd1;
        end
        for (int i = 0; i < 300; i++) begin
            step("stream", 1'b1, pat, 1'b1, 1'b0, 1'b0);
            pat = pat + 10'd1;
        end

        // Level 50 then flush with both requests active
        for (int i = 0; i < 45; i++) step("pre50", 1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
        step("flush", 1'b1, 10'h2AA, 1'b1, 1'b1, 1'b0);
        step("post_flush_wr", 1'b1, 10'h155, 1'b0, 1'b0, 1'b0);
        step("post_flush_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("idle2", 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Underflow, then coincident set/clear, then clear
        step("unf", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("unf_set_wins", 1'b0, '0, 1'b1, 1'b0, 1'b1);
        step("unf_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step("wr_rd_empty", 1'b1, 10'h0F0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic: write-heavy, then read-heavy, with rare flush/clear
        for (int i = 0; i < 800; i++) begin
            int wp;
            wp = (i < 400) ? 75 : 30;
            step("rand",
                 1'($urandom_range(0, 99) < wp),
                 DW'($urandom),
                 1'($urandom_range(0, 99) < (100 - wp)),
                 1'($urandom_range(0, 99) < 2),
                 1'($urandom_range(0, 99) < 5));
        end

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 10; i++) step("burst", 1'b1, DW'($urandom), 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("async_rst");
        #1;
        rst_n = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        step("after_rst", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step("after_rst_wr", 1'b1, 10'h3C3, 1'b0, 1'b0, 1'b0);
        step("after_rst_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dl_sync_fifo.md
Name: dl_sync_fifo

Overview:
- Parametrised single-clock FIFO for the downhole bus control board: a synchronous dual-port memory plus pointer/level control logic.
- Buffers decoded bus words between the line receiver and the uplink framer.
- Compared with the plain dual-port RAM it adds:
  - generic width and depth;
  - full/empty and programmable almost-full/almost-empty flags;
  - an occupancy count;
  - sticky overflow/underflow error flags;
  - a synchronous flush.

Parameters:
- DW, 10: data word width in bits.
- AW, 7: address width; depth = 2**AW words (default 128).
- AFULL_THR, 120: almost_full asserts when level >= AFULL_THR; legal range 1..2**AW.
- AEMPTY_THR, 8: almost_empty asserts when level <= AEMPTY_THR; legal range 0..2**AW-1.

Ports:
- clk  in  1: single clock; all logic on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- wr_en  in  1: write request.
- wr_data  in  DW: write word, sampled on an accepted write.
- rd_en  in  1: read request.
- rd_data  out  DW: read word, valid while rd_valid=1.
- rd_valid  out  1: rd_data holds the word from the read accepted on the previous edge.
- flush  in  1: synchronous empty of the FIFO.
- clr_err  in  1: synchronous clear of the sticky error flags.
- full  out  1: level == 2**AW.
- empty  out  1: level == 0.
- almost_full  out  1: level >= AFULL_THR.
- almost_empty  out  1: level <= AEMPTY_THR.
- level  out  AW+1: current occupancy, 0..2**AW.
- overflow  out  1: sticky; a write was attempted while full.
- underflow  out  1: sticky; a read was attempted while empty.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - write/read pointers = 0, level = 0;
  - empty=1, full=0, almost_full=0;
  - almost_empty=1;
  - rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - Memory contents are not reset.
  - Reset asserted mid-transfer discards all stored data and any read in flight.
- Pointers are AW+1 bits: the low AW bits address memory and the MSB is the wrap bit. Both pointers wrap modulo 2**(AW+1).
- Write acceptance: wr_en && !full && !flush. On an accepted write, mem[wptr] <= wr_data and wptr increments.
- Read acceptance: rd_en && !empty && !flush. On an accepted read, rd_data <= mem[rptr] on the same edge, rptr increments, and rd_valid=1 in the following cycle. Read latency is 1 clock.
- rd_valid is 0 in any cycle not preceded by an accepted read.
- Simultaneous write and read accepted: level unchanged and both pointers advance.
  - A write into a full FIFO is rejected even if a read is accepted on the same edge; the limit is decided on the pre-edge level.
  - A read from an empty FIFO never returns the word being written on the same edge. There is no fall-through.
- Level update:
  - +1 on a write-only edge;
  - -1 on a read-only edge;
  - 0 when both or neither are accepted.
- Flags are registered and reflect the post-edge level: full, empty, almost_full and almost_empty all change on the same edge as level.
- flush:
  - sets wptr=rptr=0, level=0, rd_valid=0 next cycle, and flags to their reset values;
  - any wr_en/rd_en in the same cycle is dropped and does not set overflow/underflow;
  - rd_data is not cleared by flush;
  - overflow/underflow are unaffected by flush.
- overflow is set on the edge where wr_en=1, full=1 and flush=0. underflow is set on the edge where rd_en=1, empty=1 and flush=0. Rejected requests have no other effect.
- clr_err clears both sticky flags. If a set condition and clr_err occur on the same edge, set wins.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: DL_FIFO_ZERO_RDATA_EN.
- Defined: rd_data is driven to 0 on every edge with no accepted read, so rd_data is 0 whenever rd_valid=0. Flush and rejected reads also give 0.
- Not defined: rd_data holds the last word read until the next accepted read.
- In both builds, rd_valid behaves identically.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, full=0, level=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
- Write 0x001..0x080 (128 words, defaults) -> level=128 and full=1 after the 128th edge; almost_full=1 from level=120; then read 128 words -> rd_data returns 0x001..0x080 in order, each one cycle after rd_en, and empty=1 at the end.
- Full FIFO, write 0x3FF -> overflow=1, level stays 128; read all 128 words -> 0x3FF never appears; pulse clr_err -> overflow=0.
- Level 5, wr_en=1 and rd_en=1 for 300 cycles with an incrementing pattern -> level stays 5; both pointers wrap at least twice; the output sequence is continuous with no loss or duplication.
- Level 50, flush with wr_en=rd_en=1 -> next cycle level=0, empty=1, rd_valid=0, no error flag set; then 1 write and 1 read -> the written word is returned.
- Empty FIFO, rd_en=1 -> underflow=1, rd_valid=0; rd_data=0 with DL_FIFO_ZERO_RDATA_EN defined, else rd_data unchanged. Assert rst_n=0 mid-burst -> all outputs take their reset values immediately, without waiting for clk.
